// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: FSM states, RV32I load/store size codes and decode helpers
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        return is_load ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                       : (f3 inside {F3_B, F3_H, F3_W});
    endfunction

    // Unsigned variants share the size bits, so f3[1:0] alone decides alignment
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero extends it
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    always_comb begin
        b    = rdata[{off, 3'b000} +: 8];
        h    = rdata[{off[1], 4'b0000} +: 16];
        sx   = ~funct3[2];
        data = funct3[1] ? rdata
             : funct3[0] ? {{(XLEN-16){h[15] & sx}}, h}
             :             {{(XLEN-8){b[7] & sx}}, b};
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/write-back stage, runs loads/stores on the data bus and drives the regfile write port
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int RSLEN    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [RSLEN-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic             ex_is_store,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  ex_sdata,
    output logic             dbus_req,
    output logic             dbus_we,
    output logic [XLEN-1:0]  dbus_addr,
    output logic [XLEN-1:0]  dbus_wdata,
    output logic [3:0]       dbus_be,
    input  logic             dbus_gnt,
    input  logic             dbus_rvalid,
    input  logic [XLEN-1:0]  dbus_rdata,
    output logic [XLEN-1:0]  wb_data,
    output logic [RSLEN-1:0] wb_addr,
    output logic             wb_e,
    output logic             mem_err
);

    state_t           state, next_state;
    logic             accept, is_mem, bad, mem_go, alu_wr, ld_wr;
    logic [RSLEN-1:0] op_rd;
    logic [2:0]       op_f3;
    logic [1:0]       op_off;
    logic [3:0]       be;
    logic [XLEN-1:0]  wdata, ld_data;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dbus_rdata),
        .off    (op_off),
        .funct3 (op_f3),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE ? (mem_go ? REQ : IDLE)
                   : state == REQ  ? (dbus_gnt ? (dbus_we ? IDLE : RSP) : REQ)
                   :                 (dbus_rvalid ? IDLE : RSP);
    end

    always_comb begin
        ex_ready = state == IDLE;
        dbus_req = state == REQ;
    end

    // Decode of the op presented by EX, only meaningful on accept
    always_comb begin
        accept = ex_valid & ex_ready;
        is_mem = ex_is_load | ex_is_store;
        bad    = (ex_is_load & ex_is_store) | ~f3_legal(ex_is_load, ex_funct3)
               | misaligned(ex_funct3, ex_result[1:0]);
        mem_go = accept & is_mem & ~bad;
        alu_wr = accept & ~is_mem & ex_we & (ex_rd != '0);
        ld_wr  = state == RSP & dbus_rvalid & (op_rd != '0);
        be     = ex_is_load  ? 4'b1111
               : ex_funct3[1] ? 4'b1111
               : ex_funct3[0] ? 4'b0011 << ex_result[1:0]
               :                4'b0001 << ex_result[1:0];
        wdata  = ex_is_load   ? '0
               : ex_funct3[1] ? ex_sdata
               : ex_funct3[0] ? {2{ex_sdata[15:0]}}
               :                {4{ex_sdata[7:0]}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
            op_rd      <= '0;
            op_f3      <= '0;
            op_off     <= '0;
            wb_data    <= '0;
            wb_addr    <= '0;
            wb_e       <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            wb_e    <= alu_wr | ld_wr;
            mem_err <= accept & is_mem & bad;
            if (mem_go) begin
                dbus_we    <= ex_is_store;
                dbus_addr  <= {ex_result[XLEN-1:2], 2'b00};
                dbus_wdata <= wdata;
                dbus_be    <= be;
                op_rd      <= ex_rd;
                op_f3      <= ex_funct3;
                op_off     <= ex_result[1:0];
            end
            if (alu_wr) begin
                wb_addr <= ex_rd;
                wb_data <= ex_result;
            end
            if (ld_wr) begin
                wb_addr <= op_rd;
                wb_data <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scenario tasks with a writeback scoreboard checked by a monitor
module tb_mem_wb_stage;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_ready, ex_we, ex_is_load, ex_is_store;
    logic [4:0]  ex_rd, wb_addr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result, ex_sdata, dbus_addr, dbus_wdata, dbus_rdata, wb_data;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, wb_e, mem_err;
    logic [3:0]  dbus_be;

    wb_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_funct3   (ex_funct3),
        .ex_result   (ex_result),
        .ex_sdata    (ex_sdata),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_be     (dbus_be),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .wb_e        (wb_e),
        .mem_err     (mem_err)
    );

    always @(negedge clk) begin
        wb_t e;
        if (wb_e) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no write", wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_addr !== e.addr || wb_data !== e.data) begin
                    fails++;
                    $display("FAIL wb_value: got addr=%0d data=%h, expected addr=%0d data=%h",
                             wb_addr, wb_data, e.addr, e.data);
                end
            end
            tests++;
            if (mem_err !== 1'b0) begin
                fails++;
                $display("FAIL wb_with_err: got mem_err=%b with wb_e, expected 0", mem_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_we = 0;
        ex_rd = 0; ex_funct3 = 0; ex_result = 0; ex_sdata = 0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic we, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd);
        ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_we = we;
        ex_funct3 = f3; ex_rd = rd; ex_result = res; ex_sdata = sd;
    endtask

    task automatic check_drain(input string name);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d writebacks outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_ex(); dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
        repeat (2) tick();
        tests++;
        if ({ex_ready, dbus_req, wb_e, mem_err, dbus_we, dbus_be} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL reset: got ready=%b req=%b wb_e=%b err=%b we=%b be=%h, expected 1 0 0 0 0 0",
                     ex_ready, dbus_req, wb_e, mem_err, dbus_we, dbus_be);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_alu();
        drive_op(0, 0, 1, 3'b000, 5'd5, 32'h1234_5678, 0);
        exp_q.push_back('{5'd5, 32'h1234_5678});
        tick();
        drive_op(0, 0, 1, 3'b000, 5'd0, 32'hFFFF_0000, 0);
        tick();
        idle_ex();
        tests++;
        if (ex_ready !== 1'b1 || wb_e !== 1'b0) begin
            fails++;
            $display("FAIL alu_rd0: got ready=%b wb_e=%b, expected 1 0", ex_ready, wb_e);
        end
        check_drain("alu");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            drive_op(0, 0, i != 2, 3'b000, 5'(i + 1), v, 0);
            if (i != 2) exp_q.push_back('{5'(i + 1), v});
            tick();
            tests++;
            if (ex_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready: got %b at op %0d, expected 1", ex_ready, i);
            end
        end
        idle_ex();
        check_drain("b2b");
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic [31:0] expd, input string name);
        drive_op(1, 0, 0, f3, rd, addr, 32'h5555_5555);
        tick();
        idle_ex();
        tests++;
        if ({dbus_req, ex_ready, dbus_we, dbus_be, dbus_addr} !== {1'b1, 1'b0, 1'b0, 4'hF, addr[31:2], 2'b00}) begin
            fails++;
            $display("FAIL %s_req: got req=%b ready=%b we=%b be=%h addr=%h, expected 1 0 0 f %h",
                     name, dbus_req, ex_ready, dbus_we, dbus_be, dbus_addr, {addr[31:2], 2'b00});
        end
        tick();
        tick();
        tests++;
        if (dbus_req !== 1'b1 || ex_ready !== 1'b0 || dbus_addr !== {addr[31:2], 2'b00}) begin
            fails++;
            $display("FAIL %s_hold: got req=%b ready=%b addr=%h, expected 1 0 %h",
                     name, dbus_req, ex_ready, dbus_addr, {addr[31:2], 2'b00});
        end
        dbus_gnt = 1;
        tick();
        dbus_gnt = 0;
        tests++;
        if (dbus_req !== 1'b0 || ex_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_rsp: got req=%b ready=%b, expected 0 0", name, dbus_req, ex_ready);
        end
        dbus_rvalid = 1;
        dbus_rdata = rdata;
        if (rd != 0) exp_q.push_back('{rd, expd});
        tick();
        dbus_rvalid = 0;
        tests++;
        if (ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: got ready=%b, expected 1", name, ex_ready);
        end
        check_drain(name);
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [3:0] ebe, input logic [31:0] ewd, input string name);
        drive_op(0, 1, 0, f3, 5'd7, addr, sdata);
        tick();
        idle_ex();
        tests++;
        if ({dbus_req, ex_ready, dbus_we, dbus_be, dbus_addr, dbus_wdata} !==
            {1'b1, 1'b0, 1'b1, ebe, addr[31:2], 2'b00, ewd}) begin
            fails++;
            $display("FAIL %s_req: got req=%b ready=%b we=%b be=%b addr=%h wdata=%h, expected 1 0 1 %b %h %h",
                     name, dbus_req, ex_ready, dbus_we, dbus_be, dbus_addr, dbus_wdata,
                     ebe, {addr[31:2], 2'b00}, ewd);
        end
        dbus_gnt = 1;
        tick();
        dbus_gnt = 0;
        tests++;
        if (dbus_req !== 1'b0 || ex_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: got req=%b ready=%b, expected 0 1", name, dbus_req, ex_ready);
        end
        check_drain(name);
    endtask

    task automatic run_err(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input string name);
        drive_op(ld, st, 1, f3, 5'd9, addr, 32'h1111_2222);
        tick();
        idle_ex();
        tests++;
        if ({mem_err, dbus_req, ex_ready, wb_e} !== 4'b1010) begin
            fails++;
            $display("FAIL %s_pulse: got err=%b req=%b ready=%b wb_e=%b, expected 1 0 1 0",
                     name, mem_err, dbus_req, ex_ready, wb_e);
        end
        tick();
        tests++;
        if (mem_err !== 1'b0 || dbus_req !== 1'b0) begin
            fails++;
            $display("FAIL %s_after: got err=%b req=%b, expected 0 0", name, mem_err, dbus_req);
        end
        check_drain(name);
    endtask

    task automatic test_loads();
        run_load(3'b000, 32'h103, 32'h80FF_0000, 5'd6,  32'hFFFF_FF80, "lb");
        run_load(3'b100, 32'h103, 32'h80FF_0000, 5'd7,  32'h0000_0080, "lbu");
        run_load(3'b001, 32'h102, 32'h8001_1234, 5'd8,  32'hFFFF_8001, "lh");
        run_load(3'b101, 32'h102, 32'h8001_1234, 5'd9,  32'h0000_8001, "lhu");
        run_load(3'b001, 32'h100, 32'h0000_F00D, 5'd12, 32'hFFFF_F00D, "lh_lo");
        run_load(3'b010, 32'h104, 32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF, "lw");
        run_load(3'b000, 32'h100, 32'h1122_337F, 5'd11, 32'h0000_007F, "lb_pos");
        run_load(3'b000, 32'h101, 32'h0000_8000, 5'd13, 32'hFFFF_FF80, "lb_b1");
        run_load(3'b010, 32'h108, 32'h0BAD_CAFE, 5'd0,  32'h0,         "lw_rd0");
    endtask

    task automatic test_stores();
        run_store(3'b001, 32'h102, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF, "sh_hi");
        run_store(3'b001, 32'h100, 32'h0000_1234, 4'b0011, 32'h1234_1234, "sh_lo");
        run_store(3'b000, 32'h201, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A, "sb");
        run_store(3'b000, 32'h203, 32'h0000_00C3, 4'b1000, 32'hC3C3_C3C3, "sb3");
        run_store(3'b010, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "sw");
    endtask

    task automatic test_errors();
        run_err(1, 0, 3'b010, 32'h101, "lw_mis");
        run_err(1, 0, 3'b011, 32'h100, "ld_f3");
        run_err(1, 0, 3'b001, 32'h101, "lh_mis");
        run_err(0, 1, 3'b100, 32'h100, "st_f3");
        run_err(0, 1, 3'b001, 32'h103, "sh_mis");
        run_err(1, 1, 3'b010, 32'h100, "ld_st");
    endtask

    task automatic test_reset_mid();
        drive_op(1, 0, 0, 3'b010, 5'd3, 32'h200, 0);
        tick();
        idle_ex();
        dbus_gnt = 1;
        tick();
        dbus_gnt = 0;
        rst = 1;
        #1;
        dbus_rvalid = 1;
        dbus_rdata = 32'h7777_7777;
        tests++;
        if (ex_ready !== 1'b1 || dbus_req !== 1'b0 || wb_e !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: got ready=%b req=%b wb_e=%b, expected 1 0 0", ex_ready, dbus_req, wb_e);
        end
        tick();
        rst = 0;
        tick();
        tick();
        dbus_rvalid = 0;
        tests++;
        if (ex_ready !== 1'b1 || dbus_req !== 1'b0 || wb_e !== 1'b0) begin
            fails++;
            $display("FAIL rst_after: got ready=%b req=%b wb_e=%b, expected 1 0 0", ex_ready, dbus_req, wb_e);
        end
        check_drain("rst_mid");
        run_load(3'b000, 32'h103, 32'h80FF_0000, 5'd6, 32'hFFFF_FF80, "lb_post_rst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
